// File: rtl/max_product_pkg.sv
// Shared types and saturating metric arithmetic for the serial max-product SISO step.
// Metric helpers work on int, so BITS must be 31 or less.
package max_product_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFinal,
        StHold
    } mps_state_e;

    function automatic int metric_max(input int unsigned bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int metric_min(input int unsigned bits);
        return -(1 << (bits - 1));
    endfunction

    function automatic int sat_add(input int a, input int b, input int unsigned bits);
        int s;
        s = a + b;
        if (s > metric_max(bits)) return metric_max(bits);
        if (s < metric_min(bits)) return metric_min(bits);
        return s;
    endfunction

    function automatic int sat_sub(input int a, input int b, input int unsigned bits);
        int s;
        s = a - b;
        if (s > metric_max(bits)) return metric_max(bits);
        if (s < metric_min(bits)) return metric_min(bits);
        return s;
    endfunction

    // Ties keep the earlier (left) operand.
    function automatic int smax(input int a, input int b);
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/max_product_symbol_serial_slice.sv
// Combinational evaluation of one trellis state: beta candidate and per-bit path maxima.
module max_product_state_slice
    import max_product_pkg::*;
#(
    parameter int unsigned BITS            = 16,
    parameter int unsigned BITS_PER_SYMBOL = 2,
    parameter int unsigned STATES          = 4,
    parameter int unsigned OUTPUT_SYMBOLS  = 4,
    localparam int unsigned INPUT_SYMBOLS  = 1 << BITS_PER_SYMBOL,
    localparam int unsigned SW             = $clog2(STATES),
    localparam int unsigned OW             = $clog2(OUTPUT_SYMBOLS)
) (
    input  logic [SW-1:0]                                      s_i,
    input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][SW-1:0]      next_state_i,
    input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][OW-1:0]      outputs_i,
    input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]                branch_metric_i,
    input  logic [STATES-1:0][BITS-1:0]                        alpha_i,
    input  logic [STATES-1:0][BITS-1:0]                        old_beta_i,
    output logic [BITS-1:0]                                    beta_acc_o,
    output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]               p0_max_o,
    output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]               p1_max_o
);

    int acc;
    int m;
    int p;
    int p0 [BITS_PER_SYMBOL];
    int p1 [BITS_PER_SYMBOL];

    always_comb begin
        acc = metric_min(BITS);
        m   = 0;
        p   = 0;
        for (int b = 0; b < int'(BITS_PER_SYMBOL); b++) begin
            p0[b] = metric_min(BITS);
            p1[b] = metric_min(BITS);
        end
        for (int u = 0; u < int'(INPUT_SYMBOLS); u++) begin
            m   = sat_add(int'($signed(branch_metric_i[outputs_i[s_i][u]])),
                          int'($signed(old_beta_i[next_state_i[s_i][u]])), BITS);
            acc = smax(acc, m);
            p   = sat_add(int'($signed(alpha_i[s_i])), m, BITS);
            for (int b = 0; b < int'(BITS_PER_SYMBOL); b++) begin
                if (((u >> b) & 1) != 0) p1[b] = smax(p1[b], p);
                else                     p0[b] = smax(p0[b], p);
            end
        end
        beta_acc_o = BITS'(acc);
        for (int b = 0; b < int'(BITS_PER_SYMBOL); b++) begin
            p0_max_o[b] = BITS'(p0[b]);
            p1_max_o[b] = BITS'(p1[b]);
        end
    end

endmodule

// File: rtl/max_product_symbol_serial.sv
// Serial max-log symbol SISO backward step, one trellis state per clock.
// Define MAX_PRODUCT_BETA_NORM_EN to normalise the new beta vector against state 0.
module max_product_symbol_serial
    import max_product_pkg::*;
#(
    parameter int unsigned BITS            = 16,
    parameter int unsigned BITS_PER_SYMBOL = 2,
    parameter int unsigned STATES          = 4,
    parameter int unsigned OUTPUT_SYMBOLS  = 4,
    localparam int unsigned INPUT_SYMBOLS  = 1 << BITS_PER_SYMBOL,
    localparam int unsigned SW             = $clog2(STATES),
    localparam int unsigned OW             = $clog2(OUTPUT_SYMBOLS)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    // Trellis tables, static for the lifetime of a step.
    input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][SW-1:0] next_state_i,
    input  logic [STATES-1:0][INPUT_SYMBOLS-1:0][OW-1:0] outputs_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]           branch_metric_i,
    input  logic [STATES-1:0][BITS-1:0]                   alpha_metric_i,
    input  logic [STATES-1:0][BITS-1:0]                   old_beta_metric_i,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [STATES-1:0][BITS-1:0]                   beta_metric_o,
    output logic [BITS_PER_SYMBOL-1:0][BITS-1:0]          llr_o
);

    localparam logic [BITS-1:0] MetricMin = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [SW-1:0]   SLast     = SW'(STATES - 1);

    mps_state_e state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [OUTPUT_SYMBOLS-1:0][BITS-1:0] bm_q, bm_d;
    logic [STATES-1:0][BITS-1:0] alpha_q, alpha_d, old_beta_q, old_beta_d;
    logic [STATES-1:0][BITS-1:0] acc_q, acc_d, beta_q, beta_d;
    logic [BITS_PER_SYMBOL-1:0][BITS-1:0] llr0_q, llr0_d, llr1_q, llr1_d, llr_q, llr_d;

    logic [BITS-1:0] slice_beta;
    logic [BITS_PER_SYMBOL-1:0][BITS-1:0] slice_p0, slice_p1;

    max_product_state_slice #(
        .BITS            (BITS),
        .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
        .STATES          (STATES),
        .OUTPUT_SYMBOLS  (OUTPUT_SYMBOLS)
    ) u_slice (
        .s_i             (s_q),
        .next_state_i    (next_state_i),
        .outputs_i       (outputs_i),
        .branch_metric_i (bm_q),
        .alpha_i         (alpha_q),
        .old_beta_i      (old_beta_q),
        .beta_acc_o      (slice_beta),
        .p0_max_o        (slice_p0),
        .p1_max_o        (slice_p1)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            s_q        <= '0;
            bm_q       <= '0;
            alpha_q    <= '0;
            old_beta_q <= '0;
            acc_q      <= {STATES{MetricMin}};
            llr0_q     <= {BITS_PER_SYMBOL{MetricMin}};
            llr1_q     <= {BITS_PER_SYMBOL{MetricMin}};
            beta_q     <= '0;
            llr_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bm_q       <= bm_d;
            alpha_q    <= alpha_d;
            old_beta_q <= old_beta_d;
            acc_q      <= acc_d;
            llr0_q     <= llr0_d;
            llr1_q     <= llr1_d;
            beta_q     <= beta_d;
            llr_q      <= llr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bm_d       = bm_q;
        alpha_d    = alpha_q;
        old_beta_d = old_beta_q;
        acc_d      = acc_q;
        llr0_d     = llr0_q;
        llr1_d     = llr1_q;
        beta_d     = beta_q;
        llr_d      = llr_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    bm_d       = branch_metric_i;
                    alpha_d    = alpha_metric_i;
                    old_beta_d = old_beta_metric_i;
                    s_d        = '0;
                    acc_d      = {STATES{MetricMin}};
                    llr0_d     = {BITS_PER_SYMBOL{MetricMin}};
                    llr1_d     = {BITS_PER_SYMBOL{MetricMin}};
                    state_d    = StAccum;
                end
            end
            StAccum: begin
                acc_d[s_q] = slice_beta;
                for (int b = 0; b < int'(BITS_PER_SYMBOL); b++) begin
                    llr0_d[b] = BITS'(smax(int'($signed(llr0_q[b])), int'($signed(slice_p0[b]))));
                    llr1_d[b] = BITS'(smax(int'($signed(llr1_q[b])), int'($signed(slice_p1[b]))));
                end
                if (s_q == SLast) state_d = StFinal;
                else              s_d     = s_q + SW'(1);
            end
            StFinal: begin
                for (int i = 0; i < int'(STATES); i++) begin
`ifdef MAX_PRODUCT_BETA_NORM_EN
                    beta_d[i] = BITS'(sat_sub(int'($signed(acc_q[i])), int'($signed(acc_q[0])),
                                              BITS));
`else
                    beta_d[i] = acc_q[i];
`endif
                end
                for (int b = 0; b < int'(BITS_PER_SYMBOL); b++) begin
                    llr_d[b] = BITS'(sat_sub(int'($signed(llr1_q[b])), int'($signed(llr0_q[b])),
                                             BITS));
                end
                state_d = StHold;
            end
            StHold: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = (state_q == StHold);
    assign beta_metric_o = beta_q;
    assign llr_o         = llr_q;

endmodule
